// File: rtl/popcount_seq_if.sv
// Handshake bundle for popcount_seq: start/data/mode towards the counter,
// busy/done/count/zero back to the controller.
interface popcount_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) ();
    logic             start;
    logic [WIDTH-1:0] data;
    logic             count_zeros;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             zero;

    modport master (
        output start, data, count_zeros,
        input  busy, done, count, zero
    );

    modport slave (
        input  start, data, count_zeros,
        output busy, done, count, zero
    );
endinterface

// File: rtl/popcount_seq.sv
// Sequential population counter: shifts the loaded word right one bit per clock,
// counting the 1s that leave bit 0, and stops as soon as the remaining bits are zero.
module popcount_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    popcount_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sr_zero_s;

    assign sr_zero_s = (sr_q == {WIDTH{1'b0}});

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        count_d = count_q;
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts start like IDLE so operations can run back to back
                if (bus.start) begin
                    sr_d    = bus.count_zeros ? ~bus.data : bus.data;
                    count_d = {CNT_W{1'b0}};
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (sr_zero_s) begin
                    state_d = DONE;
                end else begin
                    sr_d    = {1'b0, sr_q[WIDTH-1:1]};
                    count_d = count_q + {{(CNT_W-1){1'b0}}, sr_q[0]};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State, shift register, counter and status flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= {WIDTH{1'b0}};
            count_q <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.zero  = sr_zero_s;
endmodule

// File: tb/tb_popcount_seq.sv
// Scoreboard bench for popcount_seq: 8-bit and 16-bit instances, expected count
// and done latency queued at launch and compared when done appears.
module tb_popcount_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    popcount_seq_if #(.WIDTH(8))  if8 ();
    popcount_seq_if #(.WIDTH(16)) if16 ();

    popcount_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    popcount_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    typedef struct {
        int cnt;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   wide_sel = 1'b0;

    logic       sel_done, sel_busy;
    logic [4:0] sel_count;
    assign sel_done  = wide_sel ? if16.done  : if8.done;
    assign sel_busy  = wide_sel ? if16.busy  : if8.busy;
    assign sel_count = wide_sel ? if16.count : {1'b0, if8.count};

    function automatic exp_t model(input logic [15:0] d, input bit mode, input int w);
        exp_t        e;
        logic [15:0] word;
        int          top;
        word  = mode ? ~d : d;
        top   = -1;
        e.cnt = 0;
        for (int i = 0; i < w; i++) begin
            if (word[i]) begin
                e.cnt++;
                top = i;
            end
        end
        e.lat = (top < 0) ? 1 : top + 2;
        return e;
    endfunction

    task automatic drive(input bit wide, input logic [15:0] d, input bit mode, input bit st);
        if (wide) begin
            if16.data = d; if16.count_zeros = mode; if16.start = st;
        end else begin
            if8.data = d[7:0]; if8.count_zeros = mode; if8.start = st;
        end
    endtask

    // Counts negedges until done (k), and busy samples seen before it.
    task automatic wait_done(output int k, output int bcnt, output bit got);
        k = 0; bcnt = 0; got = 1'b0;
        while (!got && k < 40) begin
            if (sel_done) got = 1'b1;
            else begin
                if (sel_busy) bcnt++;
                @(negedge clk);
                k++;
            end
        end
    endtask

    task automatic run_op(input bit wide, input logic [15:0] d, input bit mode, input string name);
        exp_t e;
        int   k, b;
        bit   got;
        wide_sel = wide;
        @(negedge clk);
        drive(wide, d, mode, 1'b1);
        exp_q.push_back(model(d, mode, wide ? 16 : 8));
        @(negedge clk);
        drive(wide, d, mode, 1'b0);
        wait_done(k, b, got);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no done after %0d edges, required %0d", name, k, e.lat);
        end else begin
            checks++;
            if (k != e.lat) begin
                errors++; $display("FAIL %s latency: got %0d edges, required %0d", name, k, e.lat);
            end
            checks++;
            if (sel_count !== 5'(e.cnt)) begin
                errors++; $display("FAIL %s count: got %0d, required %0d", name, sel_count, e.cnt);
            end
            checks++;
            if (b != e.lat) begin
                errors++; $display("FAIL %s busy cycles: got %0d, required %0d", name, b, e.lat);
            end
            @(negedge clk);
            checks++;
            if (sel_done !== 1'b0 || sel_count !== 5'(e.cnt)) begin
                errors++;
                $display("FAIL %s after done: done=%b count=%0d, required done=0 count=%0d",
                         name, sel_done, sel_count, e.cnt);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.count !== 4'd0 || if8.zero !== 1'b1) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b count=%0d zero=%b, required 0 0 0 1",
                     if8.busy, if8.done, if8.count, if8.zero);
        end
        checks++;
        if (if16.busy !== 1'b0 || if16.done !== 1'b0 || if16.count !== 5'd0 || if16.zero !== 1'b1) begin
            errors++;
            $display("FAIL reset16: busy=%b done=%b count=%0d zero=%b, required 0 0 0 1",
                     if16.busy, if16.done, if16.count, if16.zero);
        end
    endtask

    task automatic test_basic();
        run_op(1'b0, 16'h00B0, 1'b0, "b0");
        run_op(1'b0, 16'h0000, 1'b0, "zero_word");
        run_op(1'b0, 16'h00FF, 1'b0, "all_ones");
        run_op(1'b0, 16'h0001, 1'b0, "lsb_only");
    endtask

    task automatic test_count_zeros();
        run_op(1'b0, 16'h00F0, 1'b1, "zeros_f0");
        run_op(1'b0, 16'h00FF, 1'b1, "zeros_ff");
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   k, b;
        bit   got;
        wide_sel = 1'b0;
        @(negedge clk);
        drive(1'b0, 16'h0080, 1'b0, 1'b1);
        exp_q.push_back(model(16'h0080, 1'b0, 8));
        @(negedge clk);
        drive(1'b0, 16'h0080, 1'b0, 1'b0);
        k = 0; b = 0; got = 1'b0;
        while (!got && k < 40) begin
            if (k == 3) drive(1'b0, 16'h0001, 1'b1, 1'b1);
            if (k == 4) drive(1'b0, 16'h0001, 1'b1, 1'b0);
            if (sel_done) got = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (!got || k != e.lat) begin
            errors++;
            $display("FAIL ignore_start latency: got=%b edges=%0d, required %0d", got, k, e.lat);
        end
        checks++;
        if (sel_count !== 5'(e.cnt)) begin
            errors++; $display("FAIL ignore_start count: got %0d, required %0d", sel_count, e.cnt);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        wide_sel = 1'b0;
        @(negedge clk);
        drive(1'b0, 16'h00FF, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'h00FF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (if8.busy !== 1'b1) begin
            errors++; $display("FAIL abort pre-reset busy: got %b, required 1", if8.busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.count !== 4'd0 || if8.zero !== 1'b1) begin
            errors++;
            $display("FAIL abort reset: busy=%b done=%b count=%0d zero=%b, required 0 0 0 1",
                     if8.busy, if8.done, if8.count, if8.zero);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done === 1'b1 || if8.busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL abort activity: got %0d busy/done cycles, required 0", dones);
        end
        run_op(1'b0, 16'h0003, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back(input bit wide);
        exp_t e;
        int   k, b;
        bit   got;
        wide_sel = wide;
        @(negedge clk);
        drive(wide, 16'h0081, 1'b0, 1'b1);
        exp_q.push_back(model(16'h0081, 1'b0, wide ? 16 : 8));
        @(negedge clk);
        wait_done(k, b, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || k != e.lat || sel_count !== 5'(e.cnt)) begin
            errors++;
            $display("FAIL b2b%0d first: got=%b edges=%0d count=%0d, required edges=%0d count=%0d",
                     wide, got, k, sel_count, e.lat, e.cnt);
        end
        drive(wide, 16'h000F, 1'b0, 1'b1);
        exp_q.push_back(model(16'h000F, 1'b0, wide ? 16 : 8));
        @(negedge clk);
        checks++;
        if (sel_done !== 1'b0 || sel_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b%0d relaunch: done=%b busy=%b, required done=0 busy=1", wide, sel_done, sel_busy);
        end
        wait_done(k, b, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || k != e.lat || sel_count !== 5'(e.cnt)) begin
            errors++;
            $display("FAIL b2b%0d second: got=%b edges=%0d count=%0d, required edges=%0d count=%0d",
                     wide, got, k, sel_count, e.lat, e.cnt);
        end
        drive(wide, 16'h000F, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (sel_done !== 1'b0 || sel_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b%0d idle: done=%b busy=%b, required 0 0", wide, sel_done, sel_busy);
        end
    endtask

    task automatic test_wide();
        run_op(1'b1, 16'h8000, 1'b0, "w_msb");
        run_op(1'b1, 16'hFFFF, 1'b1, "w_zeros_ffff");
        run_op(1'b1, 16'hA5C3, 1'b0, "w_a5c3");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        drive(1'b1, 16'h0000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_basic();
        test_count_zeros();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
